multi_cycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I-subset core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the ALU operand-2 select, ALU operation, register-file, memory and PC strobes from the instruction register contents. Sits between the instruction register and the shared single-ported datapath (register file, ALU, memory port).

---
 rtl/multi_cycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset core: FETCH/DECODE/EXECUTE/MEM/WB.
// Optional MCCTRL_ILLEGAL_TRAP_EN: illegal encodings enter a sticky TRAP state instead of executing as a NOP.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] instr,
    input  logic        memReady,
    input  logic        aluZero,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        regWrite,
    output logic        pcWrite,
    output logic        pcSrc,
    output logic [1:0]  aluIn2Sel,
    output logic [3:0]  aluOp,
    output logic        wbSel,
    output logic        trap,
    output logic [2:0]  dbgState
);

`ifdef MCCTRL_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_e;
`endif

    typedef enum logic [2:0] {
        C_ALU_R,
        C_ALU_I,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_ILLEGAL
    } cls_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    state_e     state_q, state_d;
    cls_e       cls;
    logic [1:0] sel_dec;
    logic [3:0] op_dec;
    logic       br_taken;

    logic       mem_read_c, mem_write_c, ir_write_c, reg_write_c, pc_write_c, pc_src_c, wb_sel_c;
    logic [1:0] alu_sel_c;
    logic [3:0] alu_op_c;

    logic       unused_instr;
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // funct3 -> ALU op; alt picks SUB (funct3 000) or SRA (funct3 101).
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_fn = alt ? 4'd1 : 4'd0;
            3'b001:  alu_fn = 4'd2;
            3'b010:  alu_fn = 4'd3;
            3'b011:  alu_fn = 4'd4;
            3'b100:  alu_fn = 4'd5;
            3'b101:  alu_fn = alt ? 4'd7 : 4'd6;
            3'b110:  alu_fn = 4'd8;
            default: alu_fn = 4'd9;
        endcase
    endfunction

    always_comb begin
        cls     = C_ILLEGAL;
        sel_dec = 2'b00;
        op_dec  = ALU_ADD;
        case (instr[6:0])
            7'b0110011: begin
                cls    = C_ALU_R;
                op_dec = alu_fn(instr[14:12], instr[30]);
            end
            7'b0010011: begin
                cls     = C_ALU_I;
                sel_dec = (instr[13:12] == 2'b01) ? 2'b10 : 2'b01;
                op_dec  = alu_fn(instr[14:12], instr[30] & (instr[14:12] == 3'b101));
            end
            7'b0000011: begin
                cls     = C_LOAD;
                sel_dec = 2'b01;
            end
            7'b0100011: begin
                cls     = C_STORE;
                sel_dec = 2'b01;
            end
            7'b1100011: begin
                if (instr[14:13] == 2'b00) begin
                    cls    = C_BRANCH;
                    op_dec = ALU_SUB;
                end
            end
            default: cls = C_ILLEGAL;
        endcase
    end

    // funct3[0] distinguishes BNE from BEQ.
    assign br_taken = instr[12] ? ~aluZero : aluZero;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // memRead/memWrite are the request (valid) and memReady the completion (ready): a request
    // is held every cycle until memReady is high, and the access completes in that cycle.
    always_comb begin
        state_d     = state_q;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = 1'b0;
        wb_sel_c    = 1'b0;
        alu_sel_c   = 2'b00;
        alu_op_c    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (memReady) begin
                    ir_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                state_d = (cls == C_ILLEGAL) ? S_TRAP : S_EXECUTE;
`else
                state_d = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                alu_sel_c = sel_dec;
                alu_op_c  = op_dec;
                case (cls)
                    C_BRANCH: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = br_taken;
                        state_d    = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_ALU_R, C_ALU_I: state_d = S_WB;
                    default: begin
                        // Illegal encoding retires as a NOP.
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                alu_sel_c   = 2'b01;
                alu_op_c    = ALU_ADD;
                mem_read_c  = (cls == C_LOAD);
                mem_write_c = (cls != C_LOAD);
                if (memReady) begin
                    if (cls == C_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                alu_sel_c   = sel_dec;
                alu_op_c    = op_dec;
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                wb_sel_c    = (cls == C_LOAD);
                state_d     = S_FETCH;
            end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset gates every output combinationally so an aborted access drops at once.
    assign memRead   = rstN & mem_read_c;
    assign memWrite  = rstN & mem_write_c;
    assign irWrite   = rstN & ir_write_c;
    assign regWrite  = rstN & reg_write_c;
    assign pcWrite   = rstN & pc_write_c;
    assign pcSrc     = rstN & pc_src_c;
    assign wbSel     = rstN & wb_sel_c;
    assign aluIn2Sel = rstN ? alu_sel_c : 2'b00;
    assign aluOp     = rstN ? alu_op_c : 4'd0;
    assign dbgState  = state_q;

`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign trap = rstN & (state_q == S_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized scoreboard bench for multi_cycle_ctrl; adapts to MCCTRL_ILLEGAL_TRAP_EN.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] instr;
    logic        memReady, aluZero;
    logic        memRead, memWrite, irWrite, regWrite, pcWrite, pcSrc, wbSel, trap;
    logic [1:0]  aluIn2Sel;
    logic [3:0]  aluOp;
    logic [2:0]  dbgState;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .rstN(rstN), .instr(instr), .memReady(memReady), .aluZero(aluZero),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite),
        .pcWrite(pcWrite), .pcSrc(pcSrc), .aluIn2Sel(aluIn2Sel), .aluOp(aluOp),
        .wbSel(wbSel), .trap(trap), .dbgState(dbgState)
    );

    // One record per instruction, describing what must be seen up to its single pcWrite.
    typedef struct packed {
        logic [7:0] len;
        logic [7:0] rd_cyc;
        logic [7:0] wr_cyc;
        logic       ex_chk;
        logic [1:0] ex_sel;
        logic [3:0] ex_op;
        logic       pc_src;
        logic       reg_wr;
        logic       wb_sel;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [3:0] spec_op(input logic [2:0] f3, input logic alt, input bit is_r);
        case (f3)
            3'd0:    return (is_r && alt) ? 4'd1 : 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd4;
            3'd4:    return 4'd5;
            3'd5:    return alt ? 4'd7 : 4'd6;
            3'd6:    return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    // Reference: fw = memReady-low cycles in FETCH, mw = memReady-low cycles in MEM.
    function automatic exp_t model(input logic [31:0] ins, input logic zero, input int fw, input int mw);
        exp_t       e;
        logic [2:0] f3;
        f3       = ins[14:12];
        e        = '0;
        e.ex_chk = 1'b1;
        e.rd_cyc = 8'(fw + 1);
        case (ins[6:0])
            7'h33: begin
                e.ex_op  = spec_op(f3, ins[30], 1'b1);
                e.len    = 8'(fw + 4);
                e.reg_wr = 1'b1;
            end
            7'h13: begin
                e.ex_sel = (f3 == 3'd1 || f3 == 3'd5) ? 2'b10 : 2'b01;
                e.ex_op  = spec_op(f3, ins[30], 1'b0);
                e.len    = 8'(fw + 4);
                e.reg_wr = 1'b1;
            end
            7'h03: begin
                e.ex_sel = 2'b01;
                e.len    = 8'(fw + mw + 5);
                e.rd_cyc = 8'(fw + 1 + mw + 1);
                e.reg_wr = 1'b1;
                e.wb_sel = 1'b1;
            end
            7'h23: begin
                e.ex_sel = 2'b01;
                e.len    = 8'(fw + mw + 4);
                e.wr_cyc = 8'(mw + 1);
            end
            7'h63: begin
                e.len = 8'(fw + 3);
                if (f3 == 3'd0 || f3 == 3'd1) begin
                    e.ex_op  = 4'd1;
                    e.pc_src = (f3 == 3'd0) ? zero : ~zero;
                end else begin
                    e.ex_chk = 1'b0;
                end
            end
            default: begin
                e.len    = 8'(fw + 3);
                e.ex_chk = 1'b0;
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr(input bit allow_illegal);
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = allow_illegal ? $urandom_range(0, 7) : $urandom_range(0, 6);
        case (k)
            0: begin
                r[6:0]   = 7'h33;
                r[31]    = 1'b0;
                r[29:25] = 5'd0;
            end
            1, 6: r[6:0] = 7'h13;
            2: r[6:0] = 7'h03;
            3: r[6:0] = 7'h23;
            4, 5: begin
                r[6:0]   = 7'h63;
                r[14:13] = 2'b00;
            end
            default: begin
                case ($urandom_range(0, 4))
                    0: r[6:0] = 7'h37;
                    1: r[6:0] = 7'h6F;
                    2: r[6:0] = 7'h73;
                    3: r[6:0] = 7'h7F;
                    default: begin
                        r[6:0]   = 7'h63;
                        r[14:12] = 3'($urandom_range(2, 7));
                    end
                endcase
            end
        endcase
        return r;
    endfunction

    // Drives one instruction; called at posedge+1 of its first cycle, returns at posedge+1 of the next.
    task automatic run_instr(input logic [31:0] ins, input logic zero, input int fw, input int mw);
        exp_t e;
        bit   has_mem;
        int   mem_start;
        e         = model(ins, zero, fw, mw);
        has_mem   = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h23);
        mem_start = fw + 3;
        exp_q.push_back(e);
        instr   = ins;
        aluZero = zero;
        for (int i = 0; i < int'(e.len); i++) begin
            if (i < fw) memReady = 1'b0;
            else if (i == fw) memReady = 1'b1;
            else if (has_mem && i >= mem_start) memReady = (i >= mem_start + mw);
            else memReady = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: accumulates per-instruction observations, retires on pcWrite.
    bit         mon_en;
    int         cur, rd_c, wr_c, ir_c, rw_c, ir_at;
    logic [1:0] ex_sel;
    logic [3:0] ex_op;
    bit         ovl, trap_seen;
    exp_t       mon_e;

    task automatic mon_clear();
        cur = 0; rd_c = 0; wr_c = 0; ir_c = 0; rw_c = 0; ir_at = 0;
        ex_sel = 'x; ex_op = 'x; ovl = 1'b0; trap_seen = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rstN || !mon_en) begin
            mon_clear();
        end else begin
            if (memRead) rd_c++;
            if (memWrite) wr_c++;
            if (memRead && memWrite) ovl = 1'b1;
            if (trap) trap_seen = 1'b1;
            if (regWrite) rw_c++;
            if (irWrite) begin
                if (ir_c == 0) ir_at = cur;
                ir_c++;
            end
            if (ir_c > 0 && cur == ir_at + 2) begin
                ex_sel = aluIn2Sel;
                ex_op  = aluOp;
            end
            if (pcWrite) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pcWrite", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr_cycles", cur + 1, 32'(mon_e.len));
                    check("memRead_cycles", rd_c, 32'(mon_e.rd_cyc));
                    check("memWrite_cycles", wr_c, 32'(mon_e.wr_cyc));
                    check("irWrite_count", ir_c, 32'd1);
                    if (mon_e.ex_chk) begin
                        check("ex_aluIn2Sel", 32'(ex_sel), 32'(mon_e.ex_sel));
                        check("ex_aluOp", 32'(ex_op), 32'(mon_e.ex_op));
                    end
                    check("pcSrc", 32'(pcSrc), 32'(mon_e.pc_src));
                    check("regWrite_count", rw_c, 32'(mon_e.reg_wr));
                    check("regWrite_at_pcWrite", 32'(regWrite), 32'(mon_e.reg_wr));
                    if (mon_e.reg_wr) check("wbSel", 32'(wbSel), 32'(mon_e.wb_sel));
                    check("mem_rd_wr_overlap", 32'(ovl), 32'd0);
                    check("trap_low", 32'(trap_seen), 32'd0);
                end
                mon_clear();
            end else begin
                cur++;
                if (cur > 40) begin
                    check("retire_timeout", cur, 32'd0);
                    mon_clear();
                end
            end
        end
    end

    function automatic logic [13:0] all_outs();
        return {memRead, memWrite, irWrite, regWrite, pcWrite, pcSrc, aluIn2Sel, aluOp, wbSel, trap};
    endfunction

    bit allow_illegal;
    bit bad;

    initial begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        allow_illegal = 1'b0;
`else
        allow_illegal = 1'b1;
`endif
        mon_clear();
        mon_en   = 1'b0;
        rstN     = 1'b0;
        instr    = 32'h0;
        aluZero  = 1'b0;
        memReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(all_outs()), 32'd0);
        rstN   = 1'b1;
        mon_en = 1'b1;
        #1;
        check("first_fetch_memRead", 32'(memRead), 32'd1);

        run_instr(32'h00208133, 1'b0, 0, 0);   // add
        run_instr(32'h40305093, 1'b0, 0, 0);   // srai
        run_instr(32'h00500093, 1'b0, 0, 0);   // addi
        run_instr(32'h0000A103, 1'b0, 0, 2);   // lw, two MEM waits
        run_instr(32'h00208463, 1'b1, 0, 0);   // beq taken
        run_instr(32'h00208463, 1'b0, 0, 0);   // beq not taken
        run_instr(32'h00209463, 1'b0, 2, 0);   // bne taken, fetch waits
        run_instr(32'h0020A223, 1'b0, 1, 1);   // sw
        if (allow_illegal) run_instr(32'hFFFFFFFF, 1'b0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            run_instr(rand_instr(allow_illegal), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset asserted mid-EXECUTE of an add: nothing may retire.
        instr    = 32'h00208133;
        memReady = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        check("reset_abort_outputs", 32'(all_outs()), 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold_outputs", 32'(all_outs()), 32'd0);
        rstN = 1'b1;
        #1;
        check("restart_memRead", 32'(memRead), 32'd1);
        run_instr(32'h00500093, 1'b0, 0, 0);
        run_instr(32'h0000A103, 1'b0, 1, 0);

`ifdef MCCTRL_ILLEGAL_TRAP_EN
        mon_en   = 1'b0;
        instr    = 32'hFFFFFFFF;
        memReady = 1'b1;
        @(posedge clk);
        #1;
        check("decode_strobes", 32'({memRead, memWrite, irWrite, regWrite, pcWrite, trap}), 32'd0);
        @(posedge clk);
        #1;
        check("trap_set", 32'(trap), 32'd1);
        bad = 1'b0;
        repeat (10) begin
            memReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            if ({memRead, memWrite, irWrite, regWrite, pcWrite} != 5'd0 || !trap) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check("trap_sticky_no_strobes", 32'(bad), 32'd0);
        rstN = 1'b0;
        #1;
        check("trap_cleared_by_reset", 32'(trap), 32'd0);
        @(posedge clk);
        #1;
        rstN   = 1'b1;
        mon_en = 1'b1;
        #1;
        check("post_trap_fetch", 32'(memRead), 32'd1);
        run_instr(32'h00208133, 1'b0, 0, 0);
`endif

        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
